axi_lite_reg_bridge: RTL and testbench
======================================

# axi_lite_reg_bridge

AXI4-Lite slave that converts each host read or write into one transaction on the internal register bus: req pulse, rd_wr_L, addr, wr_data out; ack and rd_data back. It sits directly upstream of the per-block register files, such as the replay micro-engine register bank. It drives their request inputs and collects their acknowledgements. Each access is serialised, and every access gets a response even when no block claims the address.

## Interface
- AXI_DATA_WIDTH, 32, data width on both sides; must be 32.
- AXI_ADDR_WIDTH, 23, AXI byte-address width; the register-bus address has the same width.
- TIMEOUT_CYCLES, 16, cycles to wait for reg_ack_in before returning an error; range 2..255.

Ports:
- clk  in  1  single clock for both sides.
- reset  in  1  asynchronous, active-high.
- s_axi_awaddr  in  AXI_ADDR_WIDTH  write byte address.
- s_axi_awvalid / s_axi_awready  in / out  1  AW handshake.
- s_axi_wdata  in  32  write data.
- s_axi_wstrb  in  4  write strobes.
- s_axi_wvalid / s_axi_wready  in / out  1  W handshake.
- s_axi_bresp  out  2  write response: 2'b00 OKAY, 2'b10 SLVERR.
- s_axi_bvalid / s_axi_bready  out / in  1  B handshake.
- s_axi_araddr  in  AXI_ADDR_WIDTH  read byte address.
- s_axi_arvalid / s_axi_arready  in / out  1  AR handshake.
- s_axi_rdata  out  32  read data.
- s_axi_rresp  out  2  read response.
- s_axi_rvalid / s_axi_rready  out / in  1  R handshake.
- reg_req_out  out  1  one-cycle request pulse to the register files.
- reg_rd_wr_L_out  out  1  1 = read, 0 = write.
- reg_addr_out  out  AXI_ADDR_WIDTH  word address: AXI address >> 2, MSBs zero-filled.
- reg_wr_data_out  out  32  write data.
- reg_ack_in  in  1  OR of all register-file acks.
- reg_rd_data_in  in  32  read data, valid in the cycle reg_ack_in = 1.

## Operation
- FSM states: IDLE, REQ, WAIT_ACK, RESP_W, RESP_R.
- **IDLE, accepting a request:**
  - A write is ready when awvalid and wvalid are both 1. A read is ready when arvalid is 1.
  - If only one is ready, that one is served.
  - If both are ready, the type not served last wins. The last-served flag resets to "read", so the first tie goes to the write.
  - For a write, awready and wready pulse high together for one cycle. For a read, arready pulses.
  - Address, wdata and direction are captured on the handshake cycle.
- **IDLE, checks on the captured request (failure goes straight to RESP_W or RESP_R with SLVERR; no bus request is issued):**
  - Misaligned address: addr[1:0] != 0.
  - Partial write strobe: wstrb != 4'hF.
- **IDLE, otherwise:** go to REQ.
- **REQ:** reg_req_out = 1 for exactly this cycle, with addr, rd_wr_L and wr_data driven. Clear the timeout counter. Go to WAIT_ACK.
- **WAIT_ACK:** the counter increments each cycle.
  - reg_ack_in = 1: capture reg_rd_data_in and set resp = OKAY. rdata is passed through unchanged, including 32'hdead_beef.
  - Counter reaches TIMEOUT_CYCLES first: set resp = SLVERR and rdata = 32'hdead_beef.
  - Either way, go to RESP_W or RESP_R.
- **RESP_W:** bvalid = 1 until bready is seen; then IDLE.
- **RESP_R:** rvalid = 1 until rready is seen; then IDLE.
  - bresp/rresp and rdata stay stable while valid is high.
- reg_ack_in outside WAIT_ACK is ignored. This covers a late ack after a timeout and a spurious ack.
- reg_addr_out, reg_rd_wr_L_out and reg_wr_data_out hold their last values outside REQ. reg_wr_data_out = 0 on reads.

## Timing
- **Reset values:** every output is 0 and the FSM is in IDLE, including all ready/valid signals, reg_req_out, reg_addr_out, reg_wr_data_out, rdata and resp. reg_rd_wr_L_out resets to 1.
- **Reset mid-transaction:** the transaction is dropped with no response. If reg_req_out was high, it drops immediately.
- **Latency with the register files (ack registered one cycle after req):**
  - Handshake in cycle 0, reg_req_out in cycle 1, reg_ack_in in cycle 2.
  - bvalid/rvalid rise in cycle 3.
  - Back-to-back throughput: one access per 4 cycles when bready/rready are held high.
- **Timeout:** with no ack, valid rises TIMEOUT_CYCLES + 2 cycles after the handshake.
- **Early-error path:** valid rises in cycle 1, with no reg_req_out.
- awready/wready/arready are never high outside IDLE, so at most one transaction is outstanding.

## Test plan
- Write 0x1234_5678 to byte address 0x4005C0: reg_req_out pulses once, with reg_addr_out = 0x100170 and rd_wr_L = 0. Model acks next cycle → bresp = OKAY, bvalid in cycle 3.
- Read the same address, model returns 0x1234_5678 → rdata = 0x1234_5678, rresp = OKAY. Holding rready = 0 for 5 cycles keeps rvalid and rdata stable.
- Read an unclaimed address (no ack) → rresp = SLVERR and rdata = 0xDEAD_BEEF exactly 18 cycles after the handshake. A late ack injected afterwards is ignored.
- Write with wstrb = 4'h3, and separately read at addr 0x4005C2 → SLVERR, with reg_req_out never asserted.
- AW/W and AR all valid in the same cycle after reset → the write is served first, then the read. Repeat the tie → alternation continues.
- Assert reset during WAIT_ACK → all outputs are 0 immediately. The next read completes normally.

Source files
------------

// File: rtl/axi_lite_reg_bridge.sv
// AXI4-Lite slave that turns each host read or write into one serialised
// register-bus transaction, with a timeout so every access gets a response.
module axi_lite_reg_bridge #(
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter int unsigned AXI_ADDR_WIDTH = 23,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [AXI_ADDR_WIDTH-1:0]     s_axi_awaddr,
  input  logic                          s_axi_awvalid,
  output logic                          s_axi_awready,
  input  logic [AXI_DATA_WIDTH-1:0]     s_axi_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0]   s_axi_wstrb,
  input  logic                          s_axi_wvalid,
  output logic                          s_axi_wready,
  output logic [1:0]                    s_axi_bresp,
  output logic                          s_axi_bvalid,
  input  logic                          s_axi_bready,
  input  logic [AXI_ADDR_WIDTH-1:0]     s_axi_araddr,
  input  logic                          s_axi_arvalid,
  output logic                          s_axi_arready,
  output logic [AXI_DATA_WIDTH-1:0]     s_axi_rdata,
  output logic [1:0]                    s_axi_rresp,
  output logic                          s_axi_rvalid,
  input  logic                          s_axi_rready,
  output logic                          reg_req_out,
  output logic                          reg_rd_wr_L_out,
  output logic [AXI_ADDR_WIDTH-1:0]     reg_addr_out,
  output logic [AXI_DATA_WIDTH-1:0]     reg_wr_data_out,
  input  logic                          reg_ack_in,
  input  logic [AXI_DATA_WIDTH-1:0]     reg_rd_data_in
);

  localparam int unsigned STRB_W = AXI_DATA_WIDTH / 8;
  localparam int unsigned CNT_W  = 8;
  localparam logic [CNT_W-1:0]          CNT_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [AXI_DATA_WIDTH-1:0] ERR_DATA    = AXI_DATA_WIDTH'(32'hdead_beef);
  localparam logic [STRB_W-1:0]         FULL_STRB   = {STRB_W{1'b1}};
  localparam logic [1:0]                RESP_OKAY   = 2'b00;
  localparam logic [1:0]                RESP_SLVERR = 2'b10;

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] REQ      = 3'd1;
  localparam logic [2:0] WAIT_ACK = 3'd2;
  localparam logic [2:0] RESP_W   = 3'd3;
  localparam logic [2:0] RESP_R   = 3'd4;

  logic [2:0]                state, state_d;
  logic [CNT_W-1:0]          cnt, cnt_d;
  logic                      last_wr, last_wr_d;
  logic                      awready_d, wready_d, arready_d;
  logic                      bvalid_d, rvalid_d;
  logic [1:0]                bresp_d, rresp_d;
  logic [AXI_DATA_WIDTH-1:0] rdata_d;
  logic                      req_d, rd_wr_d;
  logic [AXI_ADDR_WIDTH-1:0] addr_d;
  logic [AXI_DATA_WIDTH-1:0] wdata_d;
  logic                      arm;
  logic                      wr_pend_c, rd_pend_c, pick_wr_c, pick_rd_c;

  // Arbitration: on a tie, the direction not served last wins.
  assign wr_pend_c = s_axi_awvalid & s_axi_wvalid;
  assign rd_pend_c = s_axi_arvalid;
  assign pick_wr_c = wr_pend_c & (~rd_pend_c | ~last_wr);
  assign pick_rd_c = rd_pend_c & ~pick_wr_c;

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      cnt             <= '0;
      last_wr         <= 1'b0;
      s_axi_awready   <= 1'b0;
      s_axi_wready    <= 1'b0;
      s_axi_arready   <= 1'b0;
      s_axi_bvalid    <= 1'b0;
      s_axi_rvalid    <= 1'b0;
      s_axi_bresp     <= RESP_OKAY;
      s_axi_rresp     <= RESP_OKAY;
      s_axi_rdata     <= '0;
      reg_req_out     <= 1'b0;
      reg_rd_wr_L_out <= 1'b1;
      reg_addr_out    <= '0;
      reg_wr_data_out <= '0;
    end else begin
      state           <= state_d;
      cnt             <= cnt_d;
      last_wr         <= last_wr_d;
      s_axi_awready   <= awready_d;
      s_axi_wready    <= wready_d;
      s_axi_arready   <= arready_d;
      s_axi_bvalid    <= bvalid_d;
      s_axi_rvalid    <= rvalid_d;
      s_axi_bresp     <= bresp_d;
      s_axi_rresp     <= rresp_d;
      s_axi_rdata     <= rdata_d;
      reg_req_out     <= req_d;
      reg_rd_wr_L_out <= rd_wr_d;
      reg_addr_out    <= addr_d;
      reg_wr_data_out <= wdata_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    last_wr_d = last_wr;
    awready_d = 1'b0;
    wready_d  = 1'b0;
    arready_d = 1'b0;
    bvalid_d  = s_axi_bvalid;
    rvalid_d  = s_axi_rvalid;
    bresp_d   = s_axi_bresp;
    rresp_d   = s_axi_rresp;
    rdata_d   = s_axi_rdata;
    req_d     = 1'b0;
    rd_wr_d   = reg_rd_wr_L_out;
    addr_d    = reg_addr_out;
    wdata_d   = reg_wr_data_out;
    arm       = 1'b0;

    case (state)
      IDLE: begin
        // A registered ready is high: this cycle is the handshake.
        if (s_axi_awready) begin
          if (wr_pend_c) begin
            last_wr_d = 1'b1;
            if (s_axi_awaddr[1:0] != 2'b00 || s_axi_wstrb != FULL_STRB) begin
              bresp_d  = RESP_SLVERR;
              bvalid_d = 1'b1;
              state_d  = RESP_W;
            end else begin
              req_d   = 1'b1;
              rd_wr_d = 1'b0;
              addr_d  = AXI_ADDR_WIDTH'(s_axi_awaddr >> 2);
              wdata_d = s_axi_wdata;
              state_d = REQ;
            end
          end
        end else if (s_axi_arready) begin
          if (rd_pend_c) begin
            last_wr_d = 1'b0;
            if (s_axi_araddr[1:0] != 2'b00) begin
              rresp_d  = RESP_SLVERR;
              rdata_d  = ERR_DATA;
              rvalid_d = 1'b1;
              state_d  = RESP_R;
            end else begin
              req_d   = 1'b1;
              rd_wr_d = 1'b1;
              addr_d  = AXI_ADDR_WIDTH'(s_axi_araddr >> 2);
              wdata_d = '0;
              state_d = REQ;
            end
          end
        end else begin
          arm = 1'b1;
        end
      end
      REQ: begin
        cnt_d   = '0;
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        cnt_d = cnt + CNT_W'(1);
        if (reg_ack_in) begin
          if (reg_rd_wr_L_out) begin
            rdata_d  = reg_rd_data_in;
            rresp_d  = RESP_OKAY;
            rvalid_d = 1'b1;
            state_d  = RESP_R;
          end else begin
            bresp_d  = RESP_OKAY;
            bvalid_d = 1'b1;
            state_d  = RESP_W;
          end
        end else if (cnt == CNT_LAST) begin
          if (reg_rd_wr_L_out) begin
            rdata_d  = ERR_DATA;
            rresp_d  = RESP_SLVERR;
            rvalid_d = 1'b1;
            state_d  = RESP_R;
          end else begin
            bresp_d  = RESP_SLVERR;
            bvalid_d = 1'b1;
            state_d  = RESP_W;
          end
        end
      end
      RESP_W: begin
        if (s_axi_bready) begin
          bvalid_d = 1'b0;
          state_d  = IDLE;
          arm      = 1'b1;
        end
      end
      RESP_R: begin
        if (s_axi_rready) begin
          rvalid_d = 1'b0;
          state_d  = IDLE;
          arm      = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Raising ready while returning to IDLE keeps back-to-back accesses at 4 cycles.
    if (arm) begin
      awready_d = pick_wr_c;
      wready_d  = pick_wr_c;
      arready_d = pick_rd_c;
    end
  end

endmodule

// File: tb/tb_axi_lite_reg_bridge.sv
// Directed bench for axi_lite_reg_bridge: vector table plus hand-written
// sequences for arbitration, stalls, timeouts, late acks and reset.
module tb_axi_lite_reg_bridge;
  localparam int unsigned AW = 23;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [AW-1:0]   awaddr = '0, araddr = '0;
  logic            awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0;
  logic            bready = 1'b0, rready = 1'b0;
  logic [31:0]     wdata = '0;
  logic [3:0]      wstrb = '0;
  logic            awready, wready, arready, bvalid, rvalid;
  logic [1:0]      bresp, rresp;
  logic [31:0]     rdata;
  logic            reg_req, reg_rd_wr_L;
  logic [AW-1:0]   reg_addr;
  logic [31:0]     reg_wr_data;
  logic            reg_ack = 1'b0;
  logic [31:0]     reg_rd_data = '0;
  logic            inject = 1'b0, mem_clr = 1'b1, claimed;
  logic [31:0]     mem [16];

  int n_pass = 0, n_chk = 0;

  always #5 clk = ~clk;

  axi_lite_reg_bridge #(.AXI_DATA_WIDTH(32), .AXI_ADDR_WIDTH(AW), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .reg_req_out(reg_req), .reg_rd_wr_L_out(reg_rd_wr_L), .reg_addr_out(reg_addr),
    .reg_wr_data_out(reg_wr_data), .reg_ack_in(reg_ack), .reg_rd_data_in(reg_rd_data)
  );

  // Register-file stand-in: claims word addresses 0x10xxxx, acks one cycle after req.
  assign claimed = (reg_addr[20:16] == 5'h10);
  always @(posedge clk) begin
    reg_ack     <= (reg_req && claimed) || inject;
    reg_rd_data <= mem[reg_addr[3:0]];
    if (mem_clr) begin
      for (int i = 0; i < 16; i++) mem[i] <= '0;
    end else if (reg_req && !reg_rd_wr_L && claimed) begin
      mem[reg_addr[3:0]] <= reg_wr_data;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_ctl"}, 32'({awready, wready, arready, bvalid, rvalid, reg_req, reg_rd_wr_L}), 32'h1);
    chk({tag, "_resp"}, 32'({bresp, rresp}), 32'h0);
    chk({tag, "_rdata"}, rdata, 32'h0);
    chk({tag, "_addr"}, 32'(reg_addr), 32'h0);
    chk({tag, "_wdata"}, reg_wr_data, 32'h0);
  endtask

  task automatic start(input logic wr, input logic [AW-1:0] a, input logic [31:0] d,
                       input logic [3:0] s);
    @(negedge clk);
    if (wr) begin
      awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    end else begin
      araddr = a; arvalid = 1'b1;
    end
  endtask

  // Returns {awready, wready, arready} in the cycle the handshake happens (cycle 0).
  task automatic wait_hs(output logic [2:0] rdy);
    rdy = 3'b000;
    for (int i = 0; i < 10; i++) begin
      if (awready || arready) begin
        rdy = {awready, wready, arready};
        return;
      end
      @(negedge clk);
    end
  endtask

  // Counts cycles after the handshake until valid, recording any bus request.
  task automatic finish(input logic wr, output int lat, output int nreq,
                        output logic [AW-1:0] qa, output logic qrw, output logic [31:0] qwd,
                        output logic [1:0] rs, output logic [31:0] rd);
    lat = -1; nreq = 0; qa = '0; qrw = 1'b0; qwd = '0; rs = 2'b11; rd = '0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) begin
        if (wr) begin awvalid = 1'b0; wvalid = 1'b0; end
        else arvalid = 1'b0;
      end
      if (reg_req) begin
        nreq++; qa = reg_addr; qrw = reg_rd_wr_L; qwd = reg_wr_data;
      end
      if (wr ? bvalid : rvalid) begin
        lat = k; rs = wr ? bresp : rresp; rd = rdata;
        break;
      end
    end
  endtask

  task automatic ack_resp(input logic wr);
    if (wr) bready = 1'b1; else rready = 1'b1;
    @(negedge clk);
    bready = 1'b0; rready = 1'b0;
    chk("valid_drop", 32'(wr ? bvalid : rvalid), 32'h0);
  endtask

  typedef struct {
    logic            wr;
    logic [AW-1:0]   addr;
    logic [31:0]     wdata;
    logic [3:0]      strb;
    logic [1:0]      resp;
    logic [31:0]     rdata;
    logic            ck_rd;
    int              lat;
    int              nreq;
    logic [AW-1:0]   waddr;
  } vec_t;

  vec_t          vt [10];
  logic [2:0]    rdy;
  int            lat, nreq;
  logic [AW-1:0] qa;
  logic          qrw;
  logic [31:0]   qwd, rd;
  logic [1:0]    rs;

  initial begin
    vt[0] = '{1'b1, 23'h4005C0, 32'h1234_5678, 4'hF, 2'b00, 32'h0,         1'b0, 3,  1, 23'h100170};
    vt[1] = '{1'b0, 23'h4005C0, 32'h0,         4'h0, 2'b00, 32'h1234_5678, 1'b1, 3,  1, 23'h100170};
    vt[2] = '{1'b1, 23'h4005C4, 32'hdead_beef, 4'hF, 2'b00, 32'h0,         1'b0, 3,  1, 23'h100171};
    vt[3] = '{1'b0, 23'h4005C4, 32'h0,         4'h0, 2'b00, 32'hdead_beef, 1'b1, 3,  1, 23'h100171};
    vt[4] = '{1'b0, 23'h000100, 32'h0,         4'h0, 2'b10, 32'hdead_beef, 1'b1, 18, 1, 23'h000040};
    vt[5] = '{1'b1, 23'h000104, 32'haaaa_5555, 4'hF, 2'b10, 32'h0,         1'b0, 18, 1, 23'h000041};
    vt[6] = '{1'b1, 23'h4005C8, 32'hcafe_f00d, 4'h3, 2'b10, 32'h0,         1'b0, 1,  0, 23'h0};
    vt[7] = '{1'b0, 23'h4005C2, 32'h0,         4'h0, 2'b10, 32'h0,         1'b0, 1,  0, 23'h0};
    vt[8] = '{1'b1, 23'h4005C9, 32'h5555_aaaa, 4'hF, 2'b10, 32'h0,         1'b0, 1,  0, 23'h0};
    vt[9] = '{1'b0, 23'h4005C8, 32'h0,         4'h0, 2'b00, 32'h0,         1'b1, 3,  1, 23'h100172};

    repeat (3) @(negedge clk);
    mem_clr = 1'b0;
    check_reset("rst");
    reset = 1'b0;

    // Three-way tie after reset: write, then read, then write again.
    @(negedge clk);
    awaddr = 23'h4005D0; wdata = 32'h1111_2222; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 23'h4005D0; arvalid = 1'b1;
    wait_hs(rdy);
    chk("tie1_write_wins", 32'(rdy), 32'b110);
    finish(1'b1, lat, nreq, qa, qrw, qwd, rs, rd);
    chk("tie1_lat", 32'(lat), 32'd3);
    awaddr = 23'h4005D4; wdata = 32'h3333_4444; awvalid = 1'b1; wvalid = 1'b1;
    ack_resp(1'b1);
    wait_hs(rdy);
    chk("tie2_read_wins", 32'(rdy), 32'b001);
    finish(1'b0, lat, nreq, qa, qrw, qwd, rs, rd);
    chk("tie2_rdata", rd, 32'h1111_2222);
    araddr = 23'h4005D4; arvalid = 1'b1;
    ack_resp(1'b0);
    wait_hs(rdy);
    chk("tie3_write_wins", 32'(rdy), 32'b110);
    finish(1'b1, lat, nreq, qa, qrw, qwd, rs, rd);
    chk("tie3_bresp", 32'(rs), 32'h0);
    ack_resp(1'b1);
    wait_hs(rdy);
    chk("tie4_read", 32'(rdy), 32'b001);
    finish(1'b0, lat, nreq, qa, qrw, qwd, rs, rd);
    chk("tie4_rdata", rd, 32'h3333_4444);
    ack_resp(1'b0);

    for (int i = 0; i < 10; i++) begin
      start(vt[i].wr, vt[i].addr, vt[i].wdata, vt[i].strb);
      wait_hs(rdy);
      chk($sformatf("v%0d_ready", i), 32'(rdy), 32'({vt[i].wr, vt[i].wr, !vt[i].wr}));
      finish(vt[i].wr, lat, nreq, qa, qrw, qwd, rs, rd);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vt[i].lat));
      chk($sformatf("v%0d_req_count", i), 32'(nreq), 32'(vt[i].nreq));
      chk($sformatf("v%0d_resp", i), 32'(rs), 32'(vt[i].resp));
      if (vt[i].ck_rd) chk($sformatf("v%0d_rdata", i), rd, vt[i].rdata);
      if (vt[i].nreq == 1) begin
        chk($sformatf("v%0d_reg_addr", i), 32'(qa), 32'(vt[i].waddr));
        chk($sformatf("v%0d_rd_wr_L", i), 32'(qrw), 32'(!vt[i].wr));
        chk($sformatf("v%0d_reg_wdata", i), qwd, vt[i].wr ? vt[i].wdata : 32'h0);
      end
      ack_resp(vt[i].wr);
    end

    // Read held with rready low: rvalid and rdata must not move.
    start(1'b0, 23'h4005C0, 32'h0, 4'h0);
    wait_hs(rdy);
    finish(1'b0, lat, nreq, qa, qrw, qwd, rs, rd);
    chk("stall_first", rd, 32'h1234_5678);
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      chk($sformatf("stall_c%0d", s), rvalid ? rdata : 32'h0, 32'h1234_5678);
    end
    ack_resp(1'b0);

    // Timed-out read, then a late ack while rvalid is pending and another in IDLE.
    start(1'b0, 23'h000100, 32'h0, 4'h0);
    wait_hs(rdy);
    finish(1'b0, lat, nreq, qa, qrw, qwd, rs, rd);
    chk("late_lat", 32'(lat), 32'd18);
    inject = 1'b1;
    @(negedge clk);
    inject = 1'b0;
    @(negedge clk);
    chk("late_rdata", rdata, 32'hdead_beef);
    chk("late_rresp", 32'(rresp), 32'h2);
    ack_resp(1'b0);
    inject = 1'b1;
    @(negedge clk);
    inject = 1'b0;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      chk($sformatf("spurious_c%0d", s), 32'({bvalid, rvalid, reg_req, awready, arready}), 32'h0);
    end

    // Reset while reg_req_out is high.
    start(1'b0, 23'h4005C0, 32'h0, 4'h0);
    wait_hs(rdy);
    @(negedge clk);
    arvalid = 1'b0;
    chk("req_before_rst", 32'(reg_req), 32'h1);
    reset = 1'b1;
    #1;
    check_reset("rst_req");
    @(negedge clk);
    reset = 1'b0;

    // Reset in WAIT_ACK, then a normal read.
    start(1'b0, 23'h000200, 32'h0, 4'h0);
    wait_hs(rdy);
    @(negedge clk);
    arvalid = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1;
    check_reset("rst_wait");
    @(negedge clk);
    reset = 1'b0;
    start(1'b0, 23'h4005C0, 32'h0, 4'h0);
    wait_hs(rdy);
    finish(1'b0, lat, nreq, qa, qrw, qwd, rs, rd);
    chk("post_rst_lat", 32'(lat), 32'd3);
    chk("post_rst_rresp", 32'(rs), 32'h0);
    chk("post_rst_rdata", rd, 32'h1234_5678);
    ack_resp(1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
